// File: rtl/pipe_scoreboard_if.sv
// rtl/pipe_scoreboard_if.sv - ID-stage issue, control and forwarding bundle for pipe_scoreboard
interface pipe_scoreboard_if #(
  parameter int REG_AW  = 5,
  parameter int SEL_W   = 2,
  parameter int COUNT_W = 16
);
  logic              issue_valid;
  logic [REG_AW-1:0] issue_rs;
  logic [REG_AW-1:0] issue_rt;
  logic              issue_use_rs;
  logic              issue_use_rt;
  logic [REG_AW-1:0] issue_dest;
  logic              issue_wr;
  logic              issue_load;
  logic              branch_taken;
  logic              mem_busy;
  logic              stall_id;
  logic              flush_if_id;
  logic              ex_valid;
  logic [SEL_W-1:0]  fwd_a;
  logic [SEL_W-1:0]  fwd_b;
  logic [COUNT_W-1:0] stall_count;
  logic [COUNT_W-1:0] flush_count;

  modport master (
    output issue_valid, issue_rs, issue_rt, issue_use_rs, issue_use_rt,
    output issue_dest, issue_wr, issue_load, branch_taken, mem_busy,
    input  stall_id, flush_if_id, ex_valid, fwd_a, fwd_b, stall_count, flush_count
  );

  modport slave (
    input  issue_valid, issue_rs, issue_rt, issue_use_rs, issue_use_rt,
    input  issue_dest, issue_wr, issue_load, branch_taken, mem_busy,
    output stall_id, flush_if_id, ex_valid, fwd_a, fwd_b, stall_count, flush_count
  );
endinterface

// File: rtl/pipe_scoreboard.sv
// rtl/pipe_scoreboard.sv - hazard/forwarding scoreboard for the in-order pipeline
module pipe_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int COUNT_W  = 16,
  parameter int SEL_W    = $clog2(DEPTH + 1)
) (
  input logic              clk,
  input logic              rst,
  pipe_scoreboard_if.slave sb
);
  // Only p=1..DEPTH-1 are held: the writer at p=DEPTH is covered by the write-through register file.
  localparam int NSLOT = DEPTH - 1;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic              wr;
    logic              load;
  } entry_t;

  typedef struct packed {
    logic             haz;
    logic [SEL_W-1:0] sel;
  } look_t;

  entry_t [NSLOT-1:0] slot_q, slot_d;
  logic               ex_valid_q, ex_valid_d;
  logic [SEL_W-1:0]   fwd_a_q, fwd_a_d;
  logic [SEL_W-1:0]   fwd_b_q, fwd_b_d;
  logic [COUNT_W-1:0] stall_count_q, stall_count_d;
  logic [COUNT_W-1:0] flush_count_q, flush_count_d;
  look_t              look_a, look_b;
  logic               hazard;
  logic               stall_c, flush_c;

  // Youngest matching writer wins, so the scan runs oldest-to-youngest and keeps the last hit.
  function automatic look_t lookup(input entry_t [NSLOT-1:0] s, input logic use_r,
                                   input logic [REG_AW-1:0] r);
    look_t res;
    res = '0;
    if (use_r && (r != '0)) begin
      for (int p = NSLOT; p >= 1; p--) begin
        if (s[p-1].valid && s[p-1].wr && (s[p-1].dest == r)) begin
          res.sel = SEL_W'(p + 1);
          res.haz = s[p-1].load && ((p + 1) < (2 + LOAD_LAT));
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    look_a        = lookup(slot_q, sb.issue_use_rs, sb.issue_rs);
    look_b        = lookup(slot_q, sb.issue_use_rt, sb.issue_rt);
    hazard        = sb.issue_valid && (look_a.haz || look_b.haz);
    slot_d        = slot_q;
    ex_valid_d    = ex_valid_q;
    fwd_a_d       = fwd_a_q;
    fwd_b_d       = fwd_b_q;
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    stall_c       = 1'b0;
    flush_c       = 1'b0;

    if (sb.mem_busy) begin
      stall_c = 1'b1;
    end else begin
      for (int i = NSLOT - 1; i > 0; i--) begin
        slot_d[i] = slot_q[i-1];
      end
      slot_d[0] = '0;
      if (sb.branch_taken) begin
        flush_c    = 1'b1;
        ex_valid_d = 1'b0;
        fwd_a_d    = '0;
        fwd_b_d    = '0;
        if (flush_count_q != '1) flush_count_d = flush_count_q + COUNT_W'(1);
      end else if (hazard) begin
        stall_c    = 1'b1;
        ex_valid_d = 1'b0;
        fwd_a_d    = '0;
        fwd_b_d    = '0;
        if (stall_count_q != '1) stall_count_d = stall_count_q + COUNT_W'(1);
      end else begin
        if (sb.issue_valid) begin
          slot_d[0].valid = 1'b1;
          slot_d[0].dest  = sb.issue_dest;
          slot_d[0].wr    = sb.issue_wr && (sb.issue_dest != '0);
          slot_d[0].load  = sb.issue_load;
        end
        ex_valid_d = sb.issue_valid;
        fwd_a_d    = sb.issue_valid ? look_a.sel : '0;
        fwd_b_d    = sb.issue_valid ? look_b.sel : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q        <= '0;
      ex_valid_q    <= 1'b0;
      fwd_a_q       <= '0;
      fwd_b_q       <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      slot_q        <= slot_d;
      ex_valid_q    <= ex_valid_d;
      fwd_a_q       <= fwd_a_d;
      fwd_b_q       <= fwd_b_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  // While reset is held every output reads 0, including the combinational controls.
  assign sb.stall_id    = rst && stall_c;
  assign sb.flush_if_id = rst && flush_c;
  assign sb.ex_valid    = ex_valid_q;
  assign sb.fwd_a       = fwd_a_q;
  assign sb.fwd_b       = fwd_b_q;
  assign sb.stall_count = stall_count_q;
  assign sb.flush_count = flush_count_q;
endmodule

// File: tb/tb_pipe_scoreboard.sv
// tb/tb_pipe_scoreboard.sv - scoreboard bench for pipe_scoreboard against an instruction-history model
module tb_pipe_scoreboard;
  localparam int REG_AW   = 5;
  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 1;
  localparam int COUNT_W  = 4;
  localparam int SEL_W    = $clog2(DEPTH + 1);
  localparam int CMAX     = (1 << COUNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_scoreboard_if #(.REG_AW(REG_AW), .SEL_W(SEL_W), .COUNT_W(COUNT_W)) sbi ();

  pipe_scoreboard #(
    .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .COUNT_W(COUNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sb (sbi)
  );

  typedef struct { bit v; int dest; bit wr; bit ld; } instr_t;
  typedef struct { int stall; int flush; int exv; int fa; int fb; int sc; int fc; } exp_t;

  // hist[k] is what entered p=1 k advances ago, i.e. the occupant of position k+1
  instr_t hist[$];
  int     m_exv, m_fa, m_fb, m_sc, m_fc;
  exp_t   exp_q[$];
  int     vectors = 0;
  int     miscompares = 0;

  function automatic void model_clear();
    instr_t b;
    b = '{v: 1'b0, dest: 0, wr: 1'b0, ld: 1'b0};
    hist.delete();
    for (int i = 0; i < DEPTH; i++) hist.push_back(b);
    m_exv = 0; m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
  endfunction

  function automatic void lookup(input int r, input bit use_r, output bit haz, output int sel);
    int ready;
    haz = 1'b0;
    sel = 0;
    if (use_r && r != 0) begin
      for (int p = 1; p < DEPTH; p++) begin
        if (hist[p-1].v && hist[p-1].wr && hist[p-1].dest == r) begin
          ready = hist[p-1].ld ? 2 + LOAD_LAT : 2;
          sel   = p + 1;
          haz   = (p + 1) < ready;
          break;
        end
      end
    end
  endfunction

  task automatic step(input bit rn, input bit iv, input int rs, input int rt, input bit urs,
                      input bit urt, input int dest, input bit wr, input bit ld,
                      input bit br, input bit mb);
    exp_t   e;
    bit     ha, hb, haz;
    int     sa, sb;
    instr_t ent;
    @(negedge clk);
    rst              = rn;
    sbi.issue_valid  = iv;
    sbi.issue_rs     = rs[REG_AW-1:0];
    sbi.issue_rt     = rt[REG_AW-1:0];
    sbi.issue_use_rs = urs;
    sbi.issue_use_rt = urt;
    sbi.issue_dest   = dest[REG_AW-1:0];
    sbi.issue_wr     = wr;
    sbi.issue_load   = ld;
    sbi.branch_taken = br;
    sbi.mem_busy     = mb;
    if (!rn) model_clear();
    lookup(rs, urs, ha, sa);
    lookup(rt, urt, hb, sb);
    haz = iv && (ha || hb);
    e.exv = m_exv; e.fa = m_fa; e.fb = m_fb; e.sc = m_sc; e.fc = m_fc;
    if (!rn)     begin e.stall = 0;   e.flush = 0; end
    else if (mb) begin e.stall = 1;   e.flush = 0; end
    else if (br) begin e.stall = 0;   e.flush = 1; end
    else         begin e.stall = haz; e.flush = 0; end
    exp_q.push_back(e);
    if (rn && !mb) begin
      ent = '{v: 1'b0, dest: 0, wr: 1'b0, ld: 1'b0};
      if (br) begin
        m_exv = 0; m_fa = 0; m_fb = 0;
        if (m_fc < CMAX) m_fc++;
      end else if (haz) begin
        m_exv = 0; m_fa = 0; m_fb = 0;
        if (m_sc < CMAX) m_sc++;
      end else begin
        if (iv) ent = '{v: 1'b1, dest: dest, wr: wr && dest != 0, ld: ld};
        m_exv = iv;
        m_fa  = iv ? sa : 0;
        m_fb  = iv ? sb : 0;
      end
      hist.push_front(ent);
      void'(hist.pop_back());
    end
  endtask

  task automatic ins(input int dest, input bit ld, input int rs, input int rt,
                     input bit br = 1'b0, input bit mb = 1'b0);
    step(1'b1, 1'b1, rs, rt, 1'b1, 1'b1, dest, 1'b1, ld, br, mb);
  endtask

  task automatic bubble();
    step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input int expv);
    if (act !== 32'(expv)) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (vector %0d)", nm, act, expv, vectors);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        vectors++;
        chk("stall_id",    32'(sbi.stall_id),    e.stall);
        chk("flush_if_id", 32'(sbi.flush_if_id), e.flush);
        chk("ex_valid",    32'(sbi.ex_valid),    e.exv);
        chk("fwd_a",       32'(sbi.fwd_a),       e.fa);
        chk("fwd_b",       32'(sbi.fwd_b),       e.fb);
        chk("stall_count", 32'(sbi.stall_count), e.sc);
        chk("flush_count", 32'(sbi.flush_count), e.fc);
      end
    end
  end

  initial begin : driver
    model_clear();
    step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    // ALU producer forwarded from p=2
    ins(3, 1'b0, 0, 0); ins(9, 1'b0, 3, 0); bubble(); bubble();
    // load-use: one stall then forward from p=3
    ins(5, 1'b1, 0, 0); ins(9, 1'b0, 5, 0); ins(9, 1'b0, 5, 0); bubble(); bubble();
    // youngest writer wins, then older writer after a bubble
    ins(7, 1'b0, 0, 0); ins(7, 1'b0, 0, 0); ins(10, 1'b0, 0, 7); bubble();
    ins(7, 1'b0, 0, 0); bubble(); ins(10, 1'b0, 0, 7); bubble(); bubble();
    // r0 is never a forwarding source
    ins(0, 1'b0, 0, 0); ins(11, 1'b0, 0, 0); bubble(); bubble();
    // branch overrides a simultaneous load-use hazard
    ins(5, 1'b1, 0, 0); ins(9, 1'b0, 5, 0, 1'b1); bubble(); bubble();
    // freeze mid-stream, reset during the freeze, then resume
    ins(3, 1'b0, 0, 0); ins(4, 1'b0, 3, 3);
    repeat (3) ins(6, 1'b0, 4, 3, 1'b0, 1'b1);
    step(1'b0, 1'b1, 4, 3, 1'b1, 1'b1, 6, 1'b1, 1'b0, 1'b0, 1'b1);
    ins(6, 1'b0, 4, 3); ins(8, 1'b0, 6, 0); bubble();
    // randomized traffic over a small register window to provoke matches and saturation
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 5)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end
    bubble();
    repeat (3) @(negedge clk);
    #4;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipe_scoreboard.md
Name: pipe_scoreboard

Overview:
- Parametrised hazard/forwarding scoreboard for the in-order pipeline; replaces the fixed-depth hazard detection and forwarding pair.
- Tracks in-flight register writers in a DEPTH-entry shift register.
- Issues registered forward selects for the instruction in EX, plus load-use stall and branch-flush controls for IF/ID.
- Adds a variable-latency memory freeze, a configurable load latency and hazard/flush performance counters.

Parameters:
- REG_AW, 5, register address width.
- DEPTH, 3, tracked positions after ID: p=1 EX, p=2 MEM, ..., p=DEPTH WB; legal range 3..8.
- LOAD_LAT, 1, extra stages before load data can be forwarded; legal range 1..DEPTH-2.
- COUNT_W, 16, width of the performance counters.
- SEL_W, $clog2(DEPTH+1), width of the forward selects; derived, do not override.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous reset, active low; state clears immediately when rst=0.
- issue_valid  in  1  ID holds a valid instruction.
- issue_rs  in  REG_AW  source A register of the ID instruction.
- issue_rt  in  REG_AW  source B register of the ID instruction.
- issue_use_rs  in  1  ID instruction reads rs.
- issue_use_rt  in  1  ID instruction reads rt.
- issue_dest  in  REG_AW  destination register of the ID instruction.
- issue_wr  in  1  ID instruction writes its destination.
- issue_load  in  1  ID instruction is a load.
- branch_taken  in  1  branch resolved taken in EX this cycle.
- mem_busy  in  1  data memory not ready; freeze the pipeline.
- stall_id  out  1  hold PC and IF/ID (combinational).
- flush_if_id  out  1  clear IF/ID (combinational).
- ex_valid  out  1  registered; EX holds a real instruction, not a bubble.
- fwd_a  out  SEL_W  registered; operand A source for EX: 0 = register file, k = pipeline register at position k.
- fwd_b  out  SEL_W  registered; same encoding as fwd_a, for operand B.
- stall_count  out  COUNT_W  number of hazard-stall cycles.
- flush_count  out  COUNT_W  number of flush cycles.

Behaviour:
- Reset:
  - All entries invalid.
  - ex_valid=0, fwd_a=0, fwd_b=0, both counters 0.
  - stall_id and flush_if_id then evaluate to 0 until inputs cause otherwise.
- Entry fields: valid, dest, wr, load.
- Advance (mem_busy=0): entry p moves to p+1; the entry at DEPTH retires; position 1 loads either the ID instruction or a bubble.
- Ready position of a producer:
  - ALU producer: 2.
  - Load producer: 2+LOAD_LAT.
- Match, for each used operand r≠0: the smallest p in 1..DEPTH-1 with valid & wr & dest==r. The youngest producer wins.
- Hazard: a matched producer with p+1 < its ready position.
- Forward select for a matched operand with no hazard: p+1, registered into fwd_a/fwd_b on the advance. No match, or r=0, gives select 0.
  - Producers at p=DEPTH are not forwarded; the register file is write-through and covers them.
- Control priority, highest first:
  1. mem_busy=1:
     - All state frozen, including fwd_a, fwd_b, ex_valid and the counters.
     - stall_id=1, flush_if_id=0.
     - branch_taken is ignored; it is re-presented after the freeze.
  2. branch_taken=1:
     - flush_if_id=1, stall_id=0.
     - Bubble into p=1; ex_valid=0, fwd_a=0, fwd_b=0.
     - flush_count+1, saturating.
     - Any hazard in the same cycle is discarded.
  3. issue_valid & hazard:
     - stall_id=1.
     - Bubble into p=1; ex_valid=0, fwd_a=0, fwd_b=0.
     - stall_count+1, saturating.
  4. Otherwise:
     - p=1 gets {issue_valid, issue_dest, issue_wr & issue_dest≠0, issue_load}.
     - ex_valid=issue_valid; fwd_a and fwd_b take their computed selects.
- issue_valid=0: no hazard is raised; a bubble enters p=1.
- Both counters saturate at all-ones and never wrap.
- Reset taken mid-freeze or mid-stall clears all state immediately. The first edge after rst returns high behaves as a normal advance.

Test Plan (DEPTH=3, LOAD_LAT=1):
- ALU r3 issued, then consumer rs=3 next cycle -> stall_id=0; next cycle fwd_a=2, ex_valid=1.
- Load r5, then consumer rs=5 -> one cycle stall_id=1 with ex_valid=0 following; then fwd_a=3, stall_count=1.
- ALU r7 then ALU r7, then consumer rt=7 -> fwd_b=2 (youngest wins); with one bubble in between -> fwd_b=3.
- Producer dest r0, consumer rs=0 -> fwd_a=0, no stall, ALU-into-r0 entry holds wr=0.
- branch_taken together with a load-use hazard -> flush_if_id=1, stall_id=0, flush_count=1, stall_count=0, ex_valid=0.
- mem_busy held 3 cycles mid-stream -> stall_id=1 throughout; fwd_a, fwd_b, ex_valid and counters unchanged; rst pulsed low during the freeze -> all outputs 0 asynchronously.
